// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Round-robin picker: first valid request at or after ptr (wrapping) wins.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_vld  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates N_REQ writeback requesters onto the register file write port.
// Optional REGFILE_ARB_BYPASS_EN adds combinational forwarding of the in-flight write.
//
// state | meaning
// IDLE  | no write to the register file this cycle (we3=0)
// WRITE | registered write is driven to the register file (we3=1)
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      we3,
    output logic [ADDR_W-1:0]         wa3,
    output logic [DATA_W-1:0]         wd3,
    output logic                      busy
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         ra1,
    input  logic [ADDR_W-1:0]         ra2,
    input  logic [DATA_W-1:0]         rd1_in,
    input  logic [DATA_W-1:0]         rd2_in,
    output logic [DATA_W-1:0]         rd1_out,
    output logic [DATA_W-1:0]         rd2_out
`endif
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(XZR_ADDR);

    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_REQ-1:0]  grant;
    logic              grant_vld;
    logic              accept;
    logic              wr_go;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    wb_state_e         state_q, state_d;

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign accept    = grant_vld && !hold && reset_n;
    assign req_ready = accept ? grant : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // XZR writes complete the handshake but never reach the register file.
    assign wr_go = accept && (sel_addr != ZR);

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = wr_go ? WRITE : IDLE;
            WRITE:   state_d = wr_go ? WRITE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wa_q    <= '0;
            wd_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            wa_q    <= wr_go ? sel_addr : '0;
            wd_q    <= wr_go ? sel_data : '0;
            if (accept)
                ptr_q <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    assign we3  = (state_q == WRITE);
    assign busy = (state_q == WRITE);
    assign wa3  = wa_q;
    assign wd3  = wd_q;

`ifdef REGFILE_ARB_BYPASS_EN
    assign rd1_out = (we3 && wa3 == ra1 && ra1 != ZR) ? wd3 : rd1_in;
    assign rd2_out = (we3 && wa3 == ra2 && ra2 != ZR) ? wd3 : rd2_in;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed literal checks plus a random run
// compared every cycle against a behavioural round-robin model.
module tb_regfile_wb_arbiter;
    localparam int N = 2;
    localparam int AW = 5;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              hold;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              we3;
    logic [AW-1:0]     wa3;
    logic [DW-1:0]     wd3;
    logic              busy;
`ifdef REGFILE_ARB_BYPASS_EN
    logic [AW-1:0]     ra1, ra2;
    logic [DW-1:0]     rd1_in, rd2_in, rd1_out, rd2_out;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .busy      (busy)
`ifdef REGFILE_ARB_BYPASS_EN
        ,
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1_in    (rd1_in),
        .rd2_in    (rd2_in),
        .rd1_out   (rd1_out),
        .rd2_out   (rd2_out)
`endif
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pointer as an integer, one pending write slot.
    int          mptr = 0;
    bit          pend_we = 0;
    logic [4:0]  pend_a = '0;
    logic [63:0] pend_d = '0;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] eg;
        logic [4:0]   a;
        if (!reset_n) begin
            mptr = 0; pend_we = 0; pend_a = '0; pend_d = '0;
            chk("rst_ready", req_ready, 0);
            chk("rst_we3", we3, 0);
            chk("rst_wa3", wa3, 0);
            chk("rst_wd3", wd3, 0);
            chk("rst_busy", busy, 0);
`ifdef REGFILE_ARB_BYPASS_EN
            chk("rst_rd1", rd1_out, rd1_in);
            chk("rst_rd2", rd2_out, rd2_in);
`endif
        end else begin
            g = -1;
            if (!hold)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
            eg = (g >= 0) ? N'(1 << g) : '0;
            chk("m_ready", req_ready, eg);
            chk("m_we3", we3, pend_we);
            chk("m_wa3", wa3, pend_a);
            chk("m_wd3", wd3, pend_d);
            chk("m_busy", busy, pend_we);
`ifdef REGFILE_ARB_BYPASS_EN
            chk("m_rd1", rd1_out, (pend_we && pend_a == ra1 && ra1 != 31) ? pend_d : rd1_in);
            chk("m_rd2", rd2_out, (pend_we && pend_a == ra2 && ra2 != 31) ? pend_d : rd2_in);
`endif
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                mptr = (g + 1) % N;
                pend_we = (a != 31);
                pend_a  = pend_we ? a : '0;
                pend_d  = pend_we ? req_data[g*DW +: DW] : '0;
            end else begin
                pend_we = 0; pend_a = '0; pend_d = '0;
            end
        end
    end

    task automatic drive(logic [1:0] v, logic [4:0] a0, logic [63:0] d0,
                         logic [4:0] a1, logic [63:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] acc;
        reset_n = 1'b0; hold = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
`ifdef REGFILE_ARB_BYPASS_EN
        ra1 = '0; ra2 = '0; rd1_in = 64'h11; rd2_in = 64'h22;
`endif
        #1;
        chk("reset_we3", we3, 0);
        chk("reset_ready", req_ready, 0);
        repeat (2) step();
        reset_n = 1'b1;

        // 1: single write
        drive(2'b01, 5, 64'hAA, 0, 0);
        sample(); chk("t1_ready", req_ready, 2'b01);
        step(); drive(2'b00, 0, 0, 0, 0);
        sample(); chk("t1_we3", we3, 1); chk("t1_wa3", wa3, 5); chk("t1_wd3", wd3, 64'hAA);
        step(); sample(); chk("t1_we3_off", we3, 0);

        // 2: bring ptr to 0, then both valid for 4 cycles
        step(); drive(2'b10, 0, 0, 9, 64'h99);
        sample(); chk("t2_pre", req_ready, 2'b10);
        step(); drive(2'b11, 1, 64'hA0, 2, 64'hB0);
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("t2_grant", req_ready, (c % 2) ? 2'b10 : 2'b01);
            if (c > 0) begin
                chk("t2_we3", we3, 1);
                chk("t2_wd3", wd3, ((c - 1) % 2) ? 64'hB0 : 64'hA0);
            end
            step();
        end
        drive(2'b00, 0, 0, 0, 0);
        sample(); chk("t2_last_we3", we3, 1); chk("t2_last_wd3", wd3, 64'hB0);
        step(); sample(); chk("t2_off", we3, 0);

        // 3: XZR write
        step(); drive(2'b10, 0, 0, 31, 64'h55);
        sample(); chk("t3_ready", req_ready, 2'b10);
        step(); drive(2'b11, 4, 64'h44, 6, 64'h66);
        sample(); chk("t3_we3", we3, 0); chk("t3_busy", busy, 0); chk("t3_ptr", req_ready, 2'b01);

        // 4: hold
        step(); hold = 1'b1;
        sample(); chk("t4_ready", req_ready, 2'b00); chk("t4_drain", we3, 1); chk("t4_wa3", wa3, 4);
        step(); sample(); chk("t4_ready2", req_ready, 2'b00); chk("t4_we3", we3, 0);
        step(); hold = 1'b0;
        sample(); chk("t4_release", req_ready, 2'b10);
        step(); drive(2'b00, 0, 0, 0, 0);
        sample(); step();

        // 5: reset while a write is in flight
        drive(2'b01, 7, 64'h77, 0, 0);
        sample(); chk("t5_ready", req_ready, 2'b01);
        step(); drive(2'b00, 0, 0, 0, 0); #2;
        chk("t5_we3_pre", we3, 1);
        reset_n = 1'b0; #1;
        chk("t5_we3_drop", we3, 0); chk("t5_busy", busy, 0);
        sample(); chk("t5_no_write", we3, 0);
        step(); reset_n = 1'b1; drive(2'b11, 1, 64'h1, 2, 64'h2);
        sample(); chk("t5_ptr0", req_ready, 2'b01);
        step(); drive(2'b00, 0, 0, 0, 0);
        sample(); step();

`ifdef REGFILE_ARB_BYPASS_EN
        // 6: forwarding of the in-flight write
        drive(2'b01, 3, 64'h1234, 0, 0);
        step(); drive(2'b00, 0, 0, 0, 0);
        ra1 = 3; ra2 = 31; rd1_in = 64'hDEAD; rd2_in = 64'hBEEF;
        sample(); chk("t6_rd1", rd1_out, 64'h1234); chk("t6_rd2", rd2_out, 64'hBEEF);
        step();
`endif

        // random phase: payload only changes when idle or just accepted
        acc = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            hold = ($urandom_range(0, 9) < 2);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_addr[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
`ifdef REGFILE_ARB_BYPASS_EN
            ra1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            rd1_in = {$urandom, $urandom};
            rd2_in = {$urandom, $urandom};
`endif
        end
        step(); drive(2'b00, 0, 0, 0, 0); hold = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
